spi_flash_arbiter: RTL
======================

# spi_flash_arbiter

Shares the single `spi_flash_controller` between two requesters: the CPU bus interface (port A) and the boot/shadow-copy engine (port B). It arbitrates with fixed CPU priority plus a starvation limit. It sequences each transaction into the controller's `spi_ce`/`i_RW`/address/data inputs and waits for `o_MemoryReady`. It returns read data and completion, with a timeout, to the winning requester.

## Interface
- `TIMEOUT_CYCLES`, 4095: ISSUE-state cycles without ready before abort (12-bit counter).
- `GAP_CYCLES`, 2: minimum idle cycles after each completion before the next issue.
- `STARVE_LIMIT`, 4: consecutive contested CPU wins before DMA is forced.
- `clk` in 1: system clock (88.67 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `i_cpu_req` in 1: CPU request level.
- `i_cpu_rw` in 1: CPU direction, 1 = read.
- `i_cpu_addr` in 16: CPU address.
- `i_cpu_wdata` in 8: CPU write data.
- `o_cpu_done` out 1: one-cycle CPU completion pulse.
- `o_cpu_err` out 1: CPU timeout flag, valid with `o_cpu_done`.
- `o_cpu_rdata` out 8: CPU read data.
- `i_dma_req`, `i_dma_rw`, `i_dma_addr[15:0]`, `i_dma_wdata[7:0]`, `o_dma_done`, `o_dma_err`, `o_dma_rdata[7:0]`: DMA port, identical semantics to the CPU port.
- `o_spi_ce` out 1: to controller `spi_ce`.
- `o_spi_rw` out 1: to controller `i_RW`.
- `o_spi_addr` out 16: to controller `i_ADDRESS_BUS`.
- `o_spi_wdata` out 8: to controller `i_DataBus`.
- `i_spi_rdata` in 8: from controller `o_spi_data`.
- `i_spi_ready` in 1: from controller `o_MemoryReady`.
- `o_grant` out 2: one-hot owner, bit0 = CPU, bit1 = DMA.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, RECOVER.
- IDLE, no request: stay in IDLE.
- IDLE, only one requester high: grant that requester.
- IDLE, both requesters high: grant CPU, unless the starvation counter equals `STARVE_LIMIT`; then grant DMA.
- Starvation counter:
  - increments on each CPU grant made while `i_dma_req` is high;
  - clears on any DMA grant;
  - saturates at `STARVE_LIMIT`.
- On grant: latch the winner's rw/addr/wdata into `o_spi_*`, set `o_grant`, set `o_spi_ce`=1, go to ISSUE. Latched values are held for the whole transaction.
- ISSUE with `i_spi_ready`=1:
  - drop `o_spi_ce`;
  - pulse the owner's done;
  - if read, load the owner's rdata from `i_spi_rdata`; if write, rdata is unchanged;
  - err=0;
  - load the gap counter with `GAP_CYCLES`;
  - go to RECOVER.
- ISSUE timeout (counter reaches `TIMEOUT_CYCLES`): same as a normal completion, except err=1 and rdata=8'hFF on a read.
- RECOVER: gap counter decrements to 0. Exit to IDLE only when the counter is 0 and `i_spi_ready`=0. `o_grant` clears on exit.
- Requester protocol:
  - req and attributes are held stable until done;
  - req still high on the cycle after done counts as a new request;
  - dropping req mid-transaction does not abort; done still pulses.
- The non-owner port's done, err and rdata never change during another port's transaction.

## Timing
- Reset values:
  - `o_spi_ce`=0, `o_spi_rw`=1, `o_spi_addr`=0, `o_spi_wdata`=0;
  - `o_grant`=00, `o_busy`=0;
  - all done/err=0, all rdata=8'h00;
  - state IDLE, all counters 0.
- Reset asserted mid-transaction: `o_spi_ce` drops asynchronously; no done pulse is issued.
- Request seen high at IDLE edge k: `o_spi_ce`, `o_grant` and `o_busy` are high after edge k (1-cycle grant latency).
- Ready seen high at edge m: `o_spi_ce`=0 and done=1 for the cycle after edge m; rdata is valid from that same edge and held until the port's next read completion.
- Next `o_spi_ce` rise occurs no earlier than edge m+`GAP_CYCLES`+1, and only after ready has been sampled low.
- Timeout: done is asserted `TIMEOUT_CYCLES` edges after the grant edge.
- Requests arriving during ISSUE or RECOVER wait; priority is evaluated only in IDLE.

## Test plan
- CPU read, addr 16'h3AAA; ready asserted 80 cycles after ce with rdata 8'hFA:
  - `o_spi_addr`=3AAA and rw=1 while ce is high;
  - `o_cpu_done` one cycle with `o_cpu_rdata`=FA, err=0;
  - `o_dma_*` unchanged.
- DMA write, addr 16'h3000, data 8'hAA:
  - `o_spi_rw`=0 and `o_spi_wdata`=AA;
  - `o_dma_done` pulses;
  - `o_dma_rdata` keeps its previous value.
- Both requesters held high continuously:
  - grant order is CPU×4, DMA, CPU×4, DMA;
  - ce low gap of at least `GAP_CYCLES`+1 cycles between transactions.
- Ready never asserted:
  - done and err pulse exactly 4095 cycles after grant;
  - read returns rdata=FF;
  - next request proceeds normally.
- Ready held high for 10 cycles after completion: no new ce until ready falls, then the gap elapses.
- Reset pulled low in ISSUE:
  - `o_spi_ce` is 0 immediately, no done pulse, all outputs at reset values;
  - after release, a pending CPU request is granted one cycle later.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Two-port arbiter in front of the shared SPI flash controller: the CPU has fixed
// priority, the DMA port is forced through after a run of contested CPU wins.
module spi_flash_arbiter #(
   parameter int TIMEOUT_CYCLES = 4095,
   parameter int GAP_CYCLES     = 2,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_cpu_req,
   input  logic        i_cpu_rw,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_wdata,
   output logic        o_cpu_done,
   output logic        o_cpu_err,
   output logic [7:0]  o_cpu_rdata,

   input  logic        i_dma_req,
   input  logic        i_dma_rw,
   input  logic [15:0] i_dma_addr,
   input  logic [7:0]  i_dma_wdata,
   output logic        o_dma_done,
   output logic        o_dma_err,
   output logic [7:0]  o_dma_rdata,

   output logic        o_spi_ce,
   output logic        o_spi_rw,
   output logic [15:0] o_spi_addr,
   output logic [7:0]  o_spi_wdata,
   input  logic [7:0]  i_spi_rdata,
   input  logic        i_spi_ready,

   output logic [1:0]  o_grant,
   output logic        o_busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_RECOVER = 2'd2;

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [11:0]      TMO_LAST = 12'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   logic [1:0]       state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             ce_q, ce_d;
   logic             rw_q, rw_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [11:0]      tmo_q, tmo_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [STV_W-1:0] starve_q, starve_d;

   logic             cpu_done_q, cpu_done_d;
   logic             cpu_err_q, cpu_err_d;
   logic [7:0]       cpu_rdata_q, cpu_rdata_d;
   logic             dma_done_q, dma_done_d;
   logic             dma_err_q, dma_err_d;
   logic [7:0]       dma_rdata_q, dma_rdata_d;

   logic             pick_cpu;
   logic             pick_dma;
   logic             timed_out;
   logic             xfer_end;
   logic [7:0]       end_rdata;

   function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] cnt);
      if (cnt >= STV_MAX) begin
         return STV_MAX;
      end
      return cnt + STV_W'(1);
   endfunction

   // Contested arbitration: CPU wins unless DMA has been passed over STARVE_LIMIT times.
   assign pick_cpu  = i_cpu_req && !(i_dma_req && (starve_q == STV_MAX));
   assign pick_dma  = i_dma_req && !pick_cpu;

   // A ready on the last allowed cycle counts as a normal completion.
   assign timed_out = !i_spi_ready && (tmo_q == TMO_LAST);
   assign xfer_end  = (state_q == S_ISSUE) && (i_spi_ready || (tmo_q == TMO_LAST));
   assign end_rdata = timed_out ? 8'hFF : i_spi_rdata;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ce_d        = ce_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      tmo_d       = tmo_q;
      gap_d       = gap_q;
      starve_d    = starve_q;
      cpu_done_d  = 1'b0;
      cpu_err_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dma_done_d  = 1'b0;
      dma_err_d   = 1'b0;
      dma_rdata_d = dma_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (pick_cpu) begin
               state_d = S_ISSUE;
               grant_d = 2'b01;
               ce_d    = 1'b1;
               rw_d    = i_cpu_rw;
               addr_d  = i_cpu_addr;
               wdata_d = i_cpu_wdata;
               tmo_d   = '0;
               if (i_dma_req) begin
                  starve_d = starve_inc(starve_q);
               end
            end else if (pick_dma) begin
               state_d  = S_ISSUE;
               grant_d  = 2'b10;
               ce_d     = 1'b1;
               rw_d     = i_dma_rw;
               addr_d   = i_dma_addr;
               wdata_d  = i_dma_wdata;
               tmo_d    = '0;
               starve_d = '0;
            end
         end

         S_ISSUE: begin
            if (xfer_end) begin
               state_d = S_RECOVER;
               ce_d    = 1'b0;
               gap_d   = GAP_LOAD;
               tmo_d   = '0;
               if (grant_q[0]) begin
                  cpu_done_d = 1'b1;
                  cpu_err_d  = timed_out;
                  if (rw_q) begin
                     cpu_rdata_d = end_rdata;
                  end
               end
               if (grant_q[1]) begin
                  dma_done_d = 1'b1;
                  dma_err_d  = timed_out;
                  if (rw_q) begin
                     dma_rdata_d = end_rdata;
                  end
               end
            end else begin
               tmo_d = tmo_q + 12'd1;
            end
         end

         // Hold off until the gap has run out and the controller has released ready.
         S_RECOVER: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else if (!i_spi_ready) begin
               state_d = S_IDLE;
               grant_d = 2'b00;
            end
         end

         default: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            ce_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         grant_q     <= 2'b00;
         ce_q        <= 1'b0;
         rw_q        <= 1'b1;
         addr_q      <= 16'h0000;
         wdata_q     <= 8'h00;
         tmo_q       <= '0;
         gap_q       <= '0;
         starve_q    <= '0;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_rdata_q <= 8'h00;
         dma_done_q  <= 1'b0;
         dma_err_q   <= 1'b0;
         dma_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ce_q        <= ce_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tmo_q       <= tmo_d;
         gap_q       <= gap_d;
         starve_q    <= starve_d;
         cpu_done_q  <= cpu_done_d;
         cpu_err_q   <= cpu_err_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_done_q  <= dma_done_d;
         dma_err_q   <= dma_err_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign o_spi_ce    = ce_q;
   assign o_spi_rw    = rw_q;
   assign o_spi_addr  = addr_q;
   assign o_spi_wdata = wdata_q;
   assign o_grant     = grant_q;
   assign o_busy      = (state_q != S_IDLE);

   assign o_cpu_done  = cpu_done_q;
   assign o_cpu_err   = cpu_err_q;
   assign o_cpu_rdata = cpu_rdata_q;
   assign o_dma_done  = dma_done_q;
   assign o_dma_err   = dma_err_q;
   assign o_dma_rdata = dma_rdata_q;

endmodule
